// File: rtl/dispatch_unit_pkg.sv
// Shared types and constants for the dispatch stage: queue-head entry, issue bundle and
// the helper that turns one into the other.
package dispatch_unit_pkg;

  localparam int unsigned ISSUE_WIDTH = 2;
  localparam int unsigned REG_NUM     = 32;
  localparam int unsigned REG_AW      = $clog2(REG_NUM);

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Entry as it sits at the head of the decoder issue queue.
  typedef struct packed {
    logic                 inst_valid;
    logic [31:0]          pc;
    logic [7:0]           alu_op;
    logic [1:0]           reg_read_en;
    reg_addr_t [1:0]      reg_read_addr;
    logic                 reg_write_en;
    reg_addr_t            reg_write_addr;
    logic [31:0]          imm;
    logic [3:0]           is_exception;
    logic                 is_mem;
    logic                 is_privilege;
    logic                 is_multicycle;
  } id_dispatch_t;

  // Per-lane bundle handed to the execute pipes.
  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [7:0]           alu_op;
    logic [1:0]           reg_read_en;
    reg_addr_t [1:0]      reg_read_addr;
    logic                 reg_write_en;
    reg_addr_t            reg_write_addr;
    logic [31:0]          imm;
    logic [3:0]           is_exception;
    logic                 is_mem;
    logic                 is_privilege;
    logic                 is_multicycle;
  } dispatch_ex_t;

  function automatic dispatch_ex_t to_ex(input id_dispatch_t d);
    dispatch_ex_t e;
    e.valid          = 1'b1;
    e.pc             = d.pc;
    e.alu_op         = d.alu_op;
    e.reg_read_en    = d.reg_read_en;
    e.reg_read_addr  = d.reg_read_addr;
    e.reg_write_en   = d.reg_write_en;
    e.reg_write_addr = d.reg_write_addr;
    e.imm            = d.imm;
    e.is_exception   = d.is_exception;
    e.is_mem         = d.is_mem;
    e.is_privilege   = d.is_privilege;
    e.is_multicycle  = d.is_multicycle;
    return e;
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Issue-queue head interface: the queue (master) presents head entries, the dispatch
// unit (slave) answers with per-entry pop/discard strobes.
interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  id_dispatch_t [ISSUE_WIDTH-1:0] dispatch_i;
  logic [ISSUE_WIDTH-1:0]         head_valid;
  logic [ISSUE_WIDTH-1:0]         dqueue_en;
  logic [ISSUE_WIDTH-1:0]         invalid_en;

  modport master (
    output dispatch_i,
    output head_valid,
    input  dqueue_en,
    input  invalid_en
  );

  modport slave (
    input  dispatch_i,
    input  head_valid,
    output dqueue_en,
    output invalid_en
  );
endinterface

// File: rtl/dispatch_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR for long-latency producers, with a
// 2-lane x 2-source lookup port.
module dispatch_scoreboard
  import dispatch_unit_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic      [ISSUE_WIDTH-1:0]       set_en,
  input  reg_addr_t [ISSUE_WIDTH-1:0]       set_addr,
  input  logic                              clr_en,
  input  reg_addr_t                         clr_addr,
  input  reg_addr_t [ISSUE_WIDTH-1:0][1:0]  rd_addr,
  output logic      [ISSUE_WIDTH-1:0][1:0]  busy
);

  logic [REG_NUM-1:0] sb_q, sb_d;

  // Clear first so a same-cycle set of the same register wins; r0 is never busy.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_addr] = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (set_en[i]) sb_d[set_addr[i]] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Busy vector; flush drops every pending write, including a writeback in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else if (flush) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Hazard lookup for both sources of both lanes.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        busy[i][k] = sb_q[rd_addr[i][k]];
      end
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: in-order dual issue from the issue-queue head into registered per-lane
// bundles, with scoreboard-based stalls on pending long-latency writes.
module dispatch_unit
  import dispatch_unit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            pause,
  dispatch_unit_if.slave                  iq,
  input  logic                            wb_en,
  input  reg_addr_t                       wb_addr,
  output dispatch_ex_t [ISSUE_WIDTH-1:0]  dispatch_o,
  output logic                            pause_dispatch
);

  id_dispatch_t d0, d1;
  assign d0 = iq.dispatch_i[0];
  assign d1 = iq.dispatch_i[1];

  reg_addr_t [ISSUE_WIDTH-1:0][1:0] rd_addr;
  logic      [ISSUE_WIDTH-1:0][1:0] busy;
  logic      [ISSUE_WIDTH-1:0]      src_haz;
  logic      [ISSUE_WIDTH-1:0]      set_en;
  reg_addr_t [ISSUE_WIDTH-1:0]      set_addr;
  logic iss0, iss1, disc0, disc1, pop0, lane0_conflict, raw1, hold;

  assign hold = rst | flush | pause;

  dispatch_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (set_en),
    .set_addr (set_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rd_addr  (rd_addr),
    .busy     (busy)
  );

  // Source hazards; r0 reads never stall because the scoreboard never marks r0 busy.
  always_comb begin
    rd_addr[0] = d0.reg_read_addr;
    rd_addr[1] = d1.reg_read_addr;
    src_haz[0] = |(d0.reg_read_en & busy[0]);
    src_haz[1] = |(d1.reg_read_en & busy[1]);
  end

  // Issue/discard decisions. Lane 0's fields only constrain lane 1 when lane 0 actually
  // issues; a discarded lane 0 is a bubble and lets lane 1 issue on its own.
  always_comb begin
    iss0  = iq.head_valid[0] & d0.inst_valid & ~hold & ~src_haz[0];
    disc0 = iq.head_valid[0] & ~d0.inst_valid & ~hold;
    pop0  = iss0 | disc0;

    raw1 = d0.reg_write_en & (d0.reg_write_addr != '0) &
           ((d1.reg_read_en[0] & (d1.reg_read_addr[0] == d0.reg_write_addr)) |
            (d1.reg_read_en[1] & (d1.reg_read_addr[1] == d0.reg_write_addr)));
    lane0_conflict = iss0 & (raw1 | (d0.is_mem & d1.is_mem) | d0.is_privilege |
                             (d0.is_exception != '0));

    iss1  = pop0 & iq.head_valid[1] & d1.inst_valid & ~src_haz[1] & ~d1.is_privilege &
            ~lane0_conflict;
    disc1 = pop0 & iq.head_valid[1] & ~d1.inst_valid;

    iq.dqueue_en   = {iss1 | disc1, pop0};
    iq.invalid_en  = {disc1, disc0};
    pause_dispatch = iq.head_valid[0] & d0.inst_valid & src_haz[0] & ~pause & ~flush & ~rst;
  end

  // Scoreboard set requests for issued long-latency writers.
  always_comb begin
    set_en[0]   = iss0 & d0.reg_write_en & d0.is_multicycle & (d0.reg_write_addr != '0);
    set_en[1]   = iss1 & d1.reg_write_en & d1.is_multicycle & (d1.reg_write_addr != '0);
    set_addr[0] = d0.reg_write_addr;
    set_addr[1] = d1.reg_write_addr;
  end

  // Registered issue bundle: held under pause, zeroed on reset/flush and for idle lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dispatch_o <= '0;
    end else if (flush) begin
      dispatch_o <= '0;
    end else if (!pause) begin
      dispatch_o[0] <= iss0 ? to_ex(d0) : '0;
      dispatch_o[1] <= iss1 ? to_ex(d1) : '0;
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: directed scenarios followed by random traffic, all checked
// against a rule-level reference model of issue, discard and pending-register tracking.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, pause, wb_en;
  reg_addr_t wb_addr;
  dispatch_ex_t [ISSUE_WIDTH-1:0] dispatch_o;
  logic pause_dispatch;

  dispatch_unit_if iq ();

  dispatch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .pause          (pause),
    .iq             (iq),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .dispatch_o     (dispatch_o),
    .pause_dispatch (pause_dispatch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: registers with an outstanding long-latency write, expected bundle.
  bit           pend [32];
  dispatch_ex_t exp_o [2];
  logic [1:0]   e_dq, e_inv, e_iss;
  logic         e_pd;
  logic [1:0]   obs_dq, obs_inv;
  logic         obs_pd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pending(input reg_addr_t a);
    return (a != 0) && pend[a];
  endfunction

  function automatic bit reads_pending(input id_dispatch_t e);
    return (e.reg_read_en[0] && is_pending(e.reg_read_addr[0])) ||
           (e.reg_read_en[1] && is_pending(e.reg_read_addr[1]));
  endfunction

  function automatic bit reads_reg(input id_dispatch_t e, input reg_addr_t r);
    return (e.reg_read_en[0] && e.reg_read_addr[0] == r) ||
           (e.reg_read_en[1] && e.reg_read_addr[1] == r);
  endfunction

  function automatic dispatch_ex_t issued(input id_dispatch_t e);
    dispatch_ex_t r;
    r = '0;
    r.valid = 1'b1;
    r.pc = e.pc;
    r.alu_op = e.alu_op;
    r.reg_read_en = e.reg_read_en;
    r.reg_read_addr = e.reg_read_addr;
    r.reg_write_en = e.reg_write_en;
    r.reg_write_addr = e.reg_write_addr;
    r.imm = e.imm;
    r.is_exception = e.is_exception;
    r.is_mem = e.is_mem;
    r.is_privilege = e.is_privilege;
    r.is_multicycle = e.is_multicycle;
    return r;
  endfunction

  function automatic id_dispatch_t mk(input int rd, input int rs1, input int rs2,
                                      input bit we, input bit mc, input bit mem, input bit priv);
    id_dispatch_t e;
    e = '0;
    e.inst_valid = 1'b1;
    e.pc = $urandom;
    e.alu_op = 8'($urandom);
    e.imm = $urandom;
    e.reg_read_en = 2'b11;
    e.reg_read_addr[0] = 5'(rs1);
    e.reg_read_addr[1] = 5'(rs2);
    e.reg_write_en = we;
    e.reg_write_addr = 5'(rd);
    e.is_multicycle = mc;
    e.is_mem = mem;
    e.is_privilege = priv;
    return e;
  endfunction

  // Expected strobes for the inputs currently applied.
  task automatic model_eval();
    id_dispatch_t a, b;
    bit stop, i0, x0, p0, i1, x1, conflict;
    a = iq.dispatch_i[0];
    b = iq.dispatch_i[1];
    stop = rst || flush || pause;
    i0 = !stop && iq.head_valid[0] && a.inst_valid && !reads_pending(a);
    x0 = !stop && iq.head_valid[0] && !a.inst_valid;
    p0 = i0 || x0;
    conflict = i0 && ((a.reg_write_en && a.reg_write_addr != 0 &&
                       reads_reg(b, a.reg_write_addr)) ||
                      (a.is_mem && b.is_mem) || a.is_privilege || a.is_exception != 0);
    i1 = p0 && iq.head_valid[1] && b.inst_valid && !reads_pending(b) && !b.is_privilege &&
         !conflict;
    x1 = p0 && iq.head_valid[1] && !b.inst_valid;
    e_dq = {i1 || x1, p0};
    e_inv = {x1, x0};
    e_iss = {i1, i0};
    e_pd = !rst && !flush && !pause && iq.head_valid[0] && a.inst_valid && reads_pending(a);
  endtask

  // Clock-edge effect of the inputs that were applied.
  task automatic model_edge();
    id_dispatch_t e;
    if (rst || flush) begin
      foreach (pend[r]) pend[r] = 0;
      exp_o[0] = '0;
      exp_o[1] = '0;
    end else begin
      if (wb_en) pend[wb_addr] = 0;
      for (int i = 0; i < 2; i++) begin
        e = iq.dispatch_i[i];
        if (e_iss[i] && e.reg_write_en && e.is_multicycle && e.reg_write_addr != 0)
          pend[e.reg_write_addr] = 1;
      end
      if (!pause) begin
        for (int i = 0; i < 2; i++) exp_o[i] = e_iss[i] ? issued(iq.dispatch_i[i]) : '0;
      end
    end
  endtask

  task automatic step(input string tag, input logic [1:0] hv, input id_dispatch_t a,
                      input id_dispatch_t b, input bit pz, input bit fl,
                      input bit wbe, input int wba);
    iq.head_valid = hv;
    iq.dispatch_i[0] = a;
    iq.dispatch_i[1] = b;
    pause = pz;
    flush = fl;
    wb_en = wbe;
    wb_addr = 5'(wba);
    #1;
    model_eval();
    obs_dq = iq.dqueue_en;
    obs_inv = iq.invalid_en;
    obs_pd = pause_dispatch;
    chk({tag, " dqueue_en"}, 256'(obs_dq), 256'(e_dq));
    chk({tag, " invalid_en"}, 256'(obs_inv), 256'(e_inv));
    chk({tag, " pause_dispatch"}, 256'(obs_pd), 256'(e_pd));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, " dispatch_o"}, 256'(dispatch_o), 256'({exp_o[1], exp_o[0]}));
  endtask

  id_dispatch_t nop, x, y, ld7, rd7;

  initial begin
    nop = '0;
    foreach (pend[r]) pend[r] = 0;
    exp_o[0] = '0;
    exp_o[1] = '0;
    rst = 1'b1;
    flush = 1'b0;
    pause = 1'b0;
    wb_en = 1'b0;
    wb_addr = '0;
    iq.head_valid = 2'b11;
    iq.dispatch_i[0] = mk(1, 2, 3, 1, 0, 0, 0);
    iq.dispatch_i[1] = mk(4, 5, 6, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset dispatch_o", 256'(dispatch_o), 256'(0));
    chk("reset dqueue_en", 256'(iq.dqueue_en), 256'(0));
    chk("reset pause_dispatch", 256'(pause_dispatch), 256'(0));
    rst = 1'b0;

    // Independent ALU pair dual-issues.
    step("alu pair", 2'b11, mk(1, 2, 3, 1, 0, 0, 0), mk(4, 5, 6, 1, 0, 0, 0), 0, 0, 0, 0);
    chk("alu pair dq const", 256'(obs_dq), 256'(2'b11));
    chk("alu pair valids", 256'({dispatch_o[1].valid, dispatch_o[0].valid}), 256'(2'b11));

    // Lane 1 reads lane 0's destination: lane 1 waits, then issues alone.
    x = mk(1, 2, 3, 1, 0, 0, 0);
    y = mk(8, 1, 9, 1, 0, 0, 0);
    step("raw pair", 2'b11, x, y, 0, 0, 0, 0);
    chk("raw pair dq const", 256'(obs_dq), 256'(2'b01));
    step("raw follower", 2'b01, y, nop, 0, 0, 0, 0);
    chk("raw follower dq const", 256'(obs_dq), 256'(2'b01));

    // Load to r7, dependent reader stalls until writeback.
    ld7 = mk(7, 2, 3, 1, 1, 1, 0);
    rd7 = mk(9, 7, 0, 1, 0, 0, 0);
    step("load r7", 2'b01, ld7, nop, 0, 0, 0, 0);
    step("r7 stall a", 2'b01, rd7, nop, 0, 0, 0, 0);
    chk("r7 stall pd const", 256'(obs_pd), 256'(1));
    chk("r7 stall dq const", 256'(obs_dq), 256'(0));
    step("r7 stall b", 2'b01, rd7, nop, 0, 0, 0, 0);
    step("r7 wb", 2'b01, rd7, nop, 0, 0, 1, 7);
    step("r7 issue", 2'b01, rd7, nop, 0, 0, 0, 0);
    chk("r7 issue dq const", 256'(obs_dq), 256'(2'b01));

    // Two memory ops pair only lane 0; privileged lane 0 holds lane 1.
    step("two loads", 2'b11, mk(10, 2, 3, 1, 1, 1, 0), mk(11, 4, 5, 1, 1, 1, 0), 0, 0, 0, 0);
    chk("two loads dq const", 256'(obs_dq), 256'(2'b01));
    step("priv lane0", 2'b11, mk(0, 0, 0, 0, 0, 0, 1), mk(12, 4, 5, 1, 0, 0, 0), 0, 0, 1, 10);
    chk("priv lane0 dq const", 256'(obs_dq), 256'(2'b01));

    // Discarded lane 0 lets lane 1 issue by itself.
    x = mk(3, 4, 5, 1, 0, 0, 0);
    x.inst_valid = 1'b0;
    step("discard lane0", 2'b11, x, mk(13, 4, 5, 1, 0, 0, 0), 0, 0, 0, 0);
    chk("discard dq const", 256'(obs_dq), 256'(2'b11));
    chk("discard inv const", 256'(obs_inv), 256'(2'b01));
    chk("discard valids", 256'({dispatch_o[1].valid, dispatch_o[0].valid}), 256'(2'b10));

    // Set and writeback of the same register in one cycle: it stays pending.
    step("set vs wb", 2'b01, mk(14, 2, 3, 1, 1, 0, 0), nop, 0, 0, 1, 14);
    step("set wins", 2'b01, mk(15, 14, 0, 1, 0, 0, 0), nop, 0, 0, 0, 0);
    chk("set wins pd const", 256'(obs_pd), 256'(1));

    // Pending r7, three paused cycles, then flush clears everything.
    step("load r7 again", 2'b01, ld7, nop, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("paused", 2'b01, rd7, nop, 1, 0, 0, 0);
    step("flush", 2'b01, rd7, nop, 1, 1, 1, 7);
    chk("flush valids", 256'({dispatch_o[1].valid, dispatch_o[0].valid}), 256'(0));
    step("after flush", 2'b01, rd7, nop, 0, 0, 0, 0);
    chk("after flush dq const", 256'(obs_dq), 256'(2'b01));

    // Asynchronous reset pulse away from the clock edge.
    step("pre rst", 2'b01, mk(7, 1, 2, 1, 1, 1, 0), nop, 0, 0, 0, 0);
    pause = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst dispatch_o", 256'(dispatch_o), 256'(0));
    chk("async rst dq", 256'(iq.dqueue_en), 256'(0));
    foreach (pend[r]) pend[r] = 0;
    exp_o[0] = '0;
    exp_o[1] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post rst", 2'b01, rd7, nop, 0, 0, 0, 0);
    chk("post rst dq const", 256'(obs_dq), 256'(2'b01));

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      id_dispatch_t r [2];
      int wa;
      for (int i = 0; i < 2; i++) begin
        r[i] = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        r[i].reg_read_en = 2'($urandom);
        r[i].inst_valid = $urandom_range(0, 7) != 0;
        r[i].is_exception = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      wa = $urandom_range(0, 7);
      step("random", 2'($urandom), r[0], r[1], $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0, wa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
